// File: rtl/button_debouncer_bank.sv
// Bank of N_CH independent button debouncers, each a synchronizer feeding a four-state FSM.
// Optional auto-repeat while held is built only when BUTTON_REPEAT_EN is defined.
//
// state        | meaning
// IDLE         | button released and stable
// PRESS_WAIT   | sync high, counting stable cycles before accepting a press
// HELD         | press accepted, btn_level high
// RELEASE_WAIT | sync low while held, counting stable cycles before accepting a release
module button_debouncer_bank #(
  parameter int N_CH            = 5,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SYNC_STAGES     = 2,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (N_CH < 1 || N_CH > 32 || DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : gBadParams
    $error("button_debouncer_bank: illegal parameter value");
  end

`ifdef BUTTON_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_LOAD  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LOAD = REP_W'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} stateType;

  for (genvar ch = 0; ch < N_CH; ch++) begin : gCh
    logic [SYNC_STAGES-1:0] syncChain;
    logic                   sync;
    stateType               state, stateNext;
    logic [CNT_W-1:0]       cnt, cntNext;
    logic                   level, levelNext;
    logic                   press, pressNext;
    logic                   rel, relNext;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) syncChain <= '0;
      else       syncChain <= {syncChain[SYNC_STAGES-2:0], btn_in[ch]};
    end
    assign sync = syncChain[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= IDLE;
        cnt   <= '0;
        level <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        state <= stateNext;
        cnt   <= cntNext;
        level <= levelNext;
        press <= pressNext;
        rel   <= relNext;
      end
    end

`ifdef BUTTON_REPEAT_EN
    // Down-counting repeat timer; only ticks while staying in HELD, frozen in RELEASE_WAIT.
    logic [REP_W-1:0] repTimer, repNext;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) repTimer <= '0;
      else       repTimer <= repNext;
    end
`endif

    always_comb begin
      stateNext = state;
      cntNext   = cnt;
      levelNext = level;
      pressNext = 1'b0;
      relNext   = 1'b0;
`ifdef BUTTON_REPEAT_EN
      repNext   = repTimer;
`endif
      case (state)
        IDLE: begin
`ifdef BUTTON_REPEAT_EN
          repNext = '0;
`endif
          if (sync) begin
            stateNext = PRESS_WAIT;
            cntNext   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync) begin
            stateNext = IDLE;
            cntNext   = '0;
          end else if (cnt == CNT_LAST) begin
            stateNext = HELD;
            cntNext   = '0;
            levelNext = 1'b1;
            pressNext = 1'b1;
`ifdef BUTTON_REPEAT_EN
            repNext   = REP_DELAY_LOAD;
`endif
          end else begin
            cntNext = cnt + 1'b1;
          end
        end
        HELD: begin
          if (!sync) begin
            stateNext = RELEASE_WAIT;
            cntNext   = '0;
          end
`ifdef BUTTON_REPEAT_EN
          else if (repTimer == '0) begin
            pressNext = 1'b1;
            repNext   = REP_PERIOD_LOAD;
          end else begin
            repNext = repTimer - 1'b1;
          end
`endif
        end
        RELEASE_WAIT: begin
          if (sync) begin
            stateNext = HELD;
            cntNext   = '0;
          end else if (cnt == CNT_LAST) begin
            stateNext = IDLE;
            cntNext   = '0;
            levelNext = 1'b0;
            relNext   = 1'b1;
          end else begin
            cntNext = cnt + 1'b1;
          end
        end
        default: begin
          stateNext = IDLE;
          cntNext   = '0;
        end
      endcase
    end

    assign btn_level[ch]   = level;
    assign btn_press[ch]   = press;
    assign btn_release[ch] = rel;
  end

endmodule
